wb_arbiter: RTL

Writeback arbiter for the NPC pipeline: merges results from the ALU, LSU and MUL/DIV units onto the single register-file write port, and emits the matching release notification that frees the destination register in the hazard scoreboard. It sits at the end of the execute units, feeding the register file and the scoreboard's clear input. It is the consuming end of the issue-side hazard tracking, which marks registers pending; this block retires them.

---
 rtl/npc_pkg.sv | 21 ++
 rtl/wb_prio_pick.sv | 31 +++
 rtl/wb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the NPC writeback path.
//   WB_SRC_ALU/LSU/MDU : bit index of each execute unit in the source vectors
//   WB_NSRC            : number of writeback sources
//   WB_RD_W            : register-index width
//   NPC_XLEN           : default datapath width
//   wb_req_t           : one writeback request {rd, data}
package npc_pkg;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;
  localparam int WB_NSRC    = 3;
  localparam int WB_RD_W    = 5;
  localparam int NPC_XLEN   = 32;

  typedef struct packed {
    logic [WB_RD_W-1:0]  rd;
    logic [NPC_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_prio_pick.sv
// wb_prio_pick: combinational 3-way picker for the writeback arbiter.
//   valid_i    : per-source request valid
//   starving_i : per-source starving flag (all zero when starvation guard is off)
//   grant_o    : one-hot grant, zero when no source is valid
// Starving sources form the candidate set if any exist; otherwise every
// valid source does. The lowest index in the candidate set wins.
module wb_prio_pick
  import npc_pkg::*;
(
  input  logic [WB_NSRC-1:0] valid_i,
  input  logic [WB_NSRC-1:0] starving_i,
  output logic [WB_NSRC-1:0] grant_o
);

  logic [WB_NSRC-1:0] starve_valid;
  logic [WB_NSRC-1:0] cand;

  always_comb begin
    starve_valid = valid_i & starving_i;
    cand         = (|starve_valid) ? starve_valid : valid_i;
    grant_o      = '0;
    // Walk from the highest index down so the lowest candidate is the last write.
    for (int i = WB_NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU/LSU/MDU results onto the single register-file write
// port and emits the matching scoreboard release.
//   clk, rst       : clock, asynchronous active-high reset
//   src_valid      : per-source result valid (bit 0 ALU, 1 LSU, 2 MDU)
//   src_ready      : per-source accept, combinational one-hot grant
//   src_rd         : 5-bit destination per source, packed by source index
//   src_data       : XLEN-bit result per source, packed by source index
//   rf_wen/_waddr/_wdata       : register-file write, one cycle after handshake
//   sb_release/sb_release_rd   : scoreboard clear, same strobe as rf_wen
// Build option: WB_STARVE_GUARD_EN adds per-source starvation counters; a
// source refused STARVE_LIMIT cycles in a row overrides fixed priority.
// Without it, grant is pure fixed priority ALU > LSU > MDU.
//
// Handshake: a transfer happens when src_valid[i] && src_ready[i]. Sources
// hold valid/rd/data stable until accepted. src_ready depends only on
// src_valid and the counter registers and is forced low during reset.
module wb_arbiter
  import npc_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WB_NSRC-1:0]        src_valid,
  output logic [WB_NSRC-1:0]        src_ready,
  input  logic [WB_NSRC*WB_RD_W-1:0] src_rd,
  input  logic [WB_NSRC*XLEN-1:0]   src_data,
  output logic                      rf_wen,
  output logic [WB_RD_W-1:0]        rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      sb_release,
  output logic [WB_RD_W-1:0]        sb_release_rd
);

  logic [WB_NSRC-1:0] starving;
  logic [WB_NSRC-1:0] grant;

`ifdef WB_STARVE_GUARD_EN
  logic [3:0] cnt_q [WB_NSRC];
  logic [3:0] cnt_d [WB_NSRC];

  always_comb begin
    for (int i = 0; i < WB_NSRC; i++) begin
      starving[i] = (cnt_q[i] == 4'(STARVE_LIMIT));
      // Idle sources sit at zero; a refused valid source counts up and saturates.
      if (grant[i] || !src_valid[i]) begin
        cnt_d[i] = '0;
      end else if (starving[i]) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_NSRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WB_NSRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign starving = '0;
`endif

  wb_prio_pick u_pick (
    .valid_i    (src_valid),
    .starving_i (starving),
    .grant_o    (grant)
  );

  assign src_ready = rst ? '0 : grant;

  // Select the granted request; grant is one-hot so OR-reduction is a mux.
  logic [WB_RD_W-1:0] sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               hs_any;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < WB_NSRC; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd | src_rd[i*WB_RD_W +: WB_RD_W];
        sel_data = sel_data | src_data[i*XLEN +: XLEN];
      end
    end
    hs_any = |(src_valid & src_ready);
  end

  // Output stage never stalls. Writes to x0 complete the handshake but raise
  // no strobe, so x0 is never written or released.
  logic               wen_q,   wen_d;
  logic [WB_RD_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;

  always_comb begin
    wen_d   = hs_any && (sel_rd != '0);
    waddr_d = hs_any ? sel_rd : waddr_q;
    wdata_d = hs_any ? sel_data : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_wen        = wen_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
  assign sb_release    = wen_q;
  assign sb_release_rd = waddr_q;

endmodule
